// File: rtl/multdiv_issue_if.sv
// Handshake and data bundle between execute, the mult/div unit, writeback and the issue controller.
interface multdiv_issue_if;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;

    // Execute-stage request
    logic              req_valid;
    logic              req_ready;
    logic              req_isDiv;
    logic [DATA_W-1:0] req_operandA;
    logic [DATA_W-1:0] req_operandB;
    logic [REG_W-1:0]  req_rd;
    logic              busy;

    // Mult/div unit side
    logic              ctrl_MULT;
    logic              ctrl_DIV;
    logic [DATA_W-1:0] data_operandA;
    logic [DATA_W-1:0] data_operandB;
    logic [DATA_W-1:0] data_result;
    logic              data_exception;
    logic              data_resultRDY;

    // Writeback side
    logic              wb_valid;
    logic              wb_ready;
    logic [REG_W-1:0]  wb_rd;
    logic [DATA_W-1:0] wb_data;
    logic              wb_exception;

    // Environment view: execute stage, unit and writeback together
    modport master (
        output req_valid, req_isDiv, req_operandA, req_operandB, req_rd,
        output data_result, data_exception, data_resultRDY,
        output wb_ready,
        input  req_ready, busy,
        input  ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        input  wb_valid, wb_rd, wb_data, wb_exception
    );

    // Controller view
    modport slave (
        input  req_valid, req_isDiv, req_operandA, req_operandB, req_rd,
        input  data_result, data_exception, data_resultRDY,
        input  wb_ready,
        output req_ready, busy,
        output ctrl_MULT, ctrl_DIV, data_operandA, data_operandB,
        output wb_valid, wb_rd, wb_data, wb_exception
    );
endinterface

// File: rtl/multdiv_issue.sv
// Issue/writeback controller for the multiply/divide unit: accepts one op,
// pulses the unit start, waits for the result (or times out) and hands the
// result or exception status write to writeback.
module multdiv_issue #(
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned STATUS_REG  = 30,
    parameter int unsigned MULT_STATUS = 4,
    parameter int unsigned DIV_STATUS  = 5
) (
    input  logic          clock,
    input  logic          reset,
    multdiv_issue_if.slave bus
);
    localparam int unsigned DATA_W = 32;
    localparam int unsigned REG_W  = 5;
    localparam int unsigned CNT_W  = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    localparam logic [CNT_W-1:0]  CNT_LAST  = CNT_W'(TIMEOUT - 1);
    localparam logic [REG_W-1:0]  STATUS_RD = REG_W'(STATUS_REG);
    localparam logic [DATA_W-1:0] MULT_ST   = DATA_W'(MULT_STATUS);
    localparam logic [DATA_W-1:0] DIV_ST    = DATA_W'(DIV_STATUS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [CNT_W-1:0]  count;
    logic              is_div;
    logic [REG_W-1:0]  rd_q;
    logic [DATA_W-1:0] status_c;

    // Status value reported on exception or timeout, selected by op type
    assign status_c = is_div ? DIV_ST : MULT_ST;

    // Controller FSM with all outputs registered alongside the state
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            count             <= '0;
            is_div            <= 1'b0;
            rd_q              <= '0;
            bus.req_ready     <= 1'b1;
            bus.busy          <= 1'b0;
            bus.ctrl_MULT     <= 1'b0;
            bus.ctrl_DIV      <= 1'b0;
            bus.data_operandA <= '0;
            bus.data_operandB <= '0;
            bus.wb_valid      <= 1'b0;
            bus.wb_rd         <= '0;
            bus.wb_data       <= '0;
            bus.wb_exception  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    // req_ready is high throughout IDLE, so req_valid alone accepts
                    if (bus.req_valid) begin
                        state             <= START;
                        is_div            <= bus.req_isDiv;
                        rd_q              <= bus.req_rd;
                        bus.data_operandA <= bus.req_operandA;
                        bus.data_operandB <= bus.req_operandB;
                        bus.req_ready     <= 1'b0;
                        bus.busy          <= 1'b1;
                        bus.ctrl_MULT     <= ~bus.req_isDiv;
                        bus.ctrl_DIV      <= bus.req_isDiv;
                    end
                end
                START: begin
                    state         <= WAIT;
                    count         <= '0;
                    bus.ctrl_MULT <= 1'b0;
                    bus.ctrl_DIV  <= 1'b0;
                end
                WAIT: begin
                    // A ready result takes priority over a coincident timeout
                    if (bus.data_resultRDY) begin
                        state        <= DONE;
                        bus.wb_valid <= 1'b1;
                        if (bus.data_exception) begin
                            bus.wb_rd        <= STATUS_RD;
                            bus.wb_data      <= status_c;
                            bus.wb_exception <= 1'b1;
                        end else begin
                            bus.wb_rd        <= rd_q;
                            bus.wb_data      <= bus.data_result;
                            bus.wb_exception <= 1'b0;
                        end
                    end else if (count == CNT_LAST) begin
                        state            <= DONE;
                        bus.wb_valid     <= 1'b1;
                        bus.wb_rd        <= STATUS_RD;
                        bus.wb_data      <= status_c;
                        bus.wb_exception <= 1'b1;
                    end else begin
                        count <= count + CNT_W'(1);
                    end
                end
                DONE: begin
                    if (bus.wb_ready) begin
                        state         <= IDLE;
                        bus.wb_valid  <= 1'b0;
                        bus.req_ready <= 1'b1;
                        bus.busy      <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_multdiv_issue.sv
// Directed bench for multdiv_issue with a small behavioural mult/div unit.
module tb_multdiv_issue;
    logic clock = 1'b0;
    logic reset;
    int   checks   = 0;
    int   failures = 0;

    always #5 clock = ~clock;

    multdiv_issue_if mif ();

    multdiv_issue #(.TIMEOUT(8)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (mif)
    );

    // Behavioural unit: result appears unit_lat cycles after the start pulse
    int                 unit_lat = 1;
    bit                 unit_en  = 1'b1;
    int                 cnt_m    = 0;
    bit                 m_isdiv  = 1'b0;
    logic [31:0]        m_a      = '0;
    logic [31:0]        m_b      = '0;
    logic signed [63:0] m_prod;
    logic               model_rdy = 1'b0;
    logic               model_exc = 1'b0;
    logic [31:0]        model_res = '0;
    logic               late_rdy  = 1'b0;
    logic [31:0]        late_res  = '0;
    int                 mult_pulses = 0;
    int                 div_pulses  = 0;

    assign mif.data_resultRDY = model_rdy | late_rdy;
    assign mif.data_result    = late_rdy ? late_res : model_res;
    assign mif.data_exception = late_rdy ? 1'b0 : model_exc;

    always @(posedge clock) begin
        #1;
        model_rdy = 1'b0;
        if (mif.ctrl_MULT) mult_pulses++;
        if (mif.ctrl_DIV)  div_pulses++;
        if (mif.ctrl_MULT || mif.ctrl_DIV) begin
            cnt_m   = unit_lat;
            m_isdiv = mif.ctrl_DIV;
            m_a     = mif.data_operandA;
            m_b     = mif.data_operandB;
        end else if (cnt_m > 0) begin
            cnt_m--;
            if (cnt_m == 0 && unit_en) begin
                model_rdy = 1'b1;
                if (m_isdiv) begin
                    model_exc = (m_b == 32'd0);
                    model_res = model_exc ? 32'd0 : 32'($signed(m_a) / $signed(m_b));
                end else begin
                    m_prod    = 64'($signed(m_a)) * 64'($signed(m_b));
                    model_res = m_prod[31:0];
                    model_exc = (m_prod != {{32{m_prod[31]}}, m_prod[31:0]});
                end
            end
        end
    end

    // Present a request and wait (bounded) for its accept edge; returns #1 after it
    task automatic send_req(input bit isdiv, input logic [31:0] a, input logic [31:0] b,
                            input logic [4:0] rd, output int waited, output bit ok);
        mif.req_valid    = 1'b1;
        mif.req_isDiv    = isdiv;
        mif.req_operandA = a;
        mif.req_operandB = b;
        mif.req_rd       = rd;
        ok     = 1'b0;
        waited = 0;
        while (!ok && waited < 40) begin
            if (mif.req_ready) ok = 1'b1;
            @(posedge clock);
            #1;
            if (!ok) waited++;
        end
        mif.req_valid = 1'b0;
    endtask

    // Wait (bounded) for wb_valid; cycles counts edges after the accept edge
    task automatic wait_wb(input int max, output int cycles, output bit ok);
        cycles = 0;
        while (!mif.wb_valid && cycles < max) begin
            @(posedge clock);
            #1;
            cycles++;
        end
        ok = mif.wb_valid;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        checks++;
        if ({mif.req_ready, mif.busy, mif.ctrl_MULT, mif.ctrl_DIV, mif.wb_valid, mif.wb_exception} !== 6'b100000) begin
            failures++;
            $display("FAIL reset_ctrl: got %b required 100000",
                     {mif.req_ready, mif.busy, mif.ctrl_MULT, mif.ctrl_DIV, mif.wb_valid, mif.wb_exception});
        end
        checks++;
        if ({mif.data_operandA, mif.data_operandB} !== 64'd0) begin
            failures++;
            $display("FAIL reset_operands: got %h %h required 0 0", mif.data_operandA, mif.data_operandB);
        end
        checks++;
        if ({mif.wb_rd, mif.wb_data} !== 37'd0) begin
            failures++;
            $display("FAIL reset_wb: got rd=%0d data=%h required 0 0", mif.wb_rd, mif.wb_data);
        end
        @(posedge clock);
        #1 reset = 1'b0;
    endtask

    task automatic test_mult();
        int cyc, w;
        bit ok;
        unit_lat    = 1;
        mult_pulses = 0;
        div_pulses  = 0;
        send_req(1'b0, 32'd7, 32'd6, 5'd3, w, ok);
        checks++;
        if (!ok || mif.data_operandA !== 32'd7 || mif.data_operandB !== 32'd6) begin
            failures++;
            $display("FAIL mult_accept: ok=%0d operands %0d %0d required 7 6", ok, mif.data_operandA, mif.data_operandB);
        end
        wait_wb(20, cyc, ok);
        checks++;
        if (!ok || cyc !== 2) begin
            failures++;
            $display("FAIL mult_latency: got %0d edges after accept (valid=%0d) required 2", cyc, ok);
        end
        checks++;
        if ({mif.wb_rd, mif.wb_data, mif.wb_exception} !== {5'd3, 32'd42, 1'b0}) begin
            failures++;
            $display("FAIL mult_result: got rd=%0d data=%0d exc=%0d required 3 42 0", mif.wb_rd, mif.wb_data, mif.wb_exception);
        end
        @(posedge clock);
        #1;
        checks++;
        if ({mif.wb_valid, mif.req_ready, mif.busy} !== 3'b010) begin
            failures++;
            $display("FAIL mult_release: got valid/ready/busy=%b required 010", {mif.wb_valid, mif.req_ready, mif.busy});
        end
        checks++;
        if (mult_pulses !== 1 || div_pulses !== 0) begin
            failures++;
            $display("FAIL mult_pulse: got mult=%0d div=%0d cycles required 1 0", mult_pulses, div_pulses);
        end
    endtask

    task automatic test_div();
        int cyc, w;
        bit ok;
        unit_lat    = 3;
        mult_pulses = 0;
        div_pulses  = 0;
        send_req(1'b1, 32'd100, 32'd7, 5'd9, w, ok);
        wait_wb(20, cyc, ok);
        checks++;
        if (!ok || cyc !== 4 || {mif.wb_rd, mif.wb_data, mif.wb_exception} !== {5'd9, 32'd14, 1'b0}) begin
            failures++;
            $display("FAIL div_pos: got edges=%0d rd=%0d data=%0d exc=%0d required 4 9 14 0",
                     cyc, mif.wb_rd, mif.wb_data, mif.wb_exception);
        end
        @(posedge clock);
        #1;
        send_req(1'b1, 32'hFFFF_FF9C, 32'd7, 5'd10, w, ok);
        wait_wb(20, cyc, ok);
        checks++;
        if (!ok || {mif.wb_rd, mif.wb_data, mif.wb_exception} !== {5'd10, 32'hFFFF_FFF2, 1'b0}) begin
            failures++;
            $display("FAIL div_neg: got rd=%0d data=%h exc=%0d required 10 fffffff2 0", mif.wb_rd, mif.wb_data, mif.wb_exception);
        end
        @(posedge clock);
        #1;
        checks++;
        if (mult_pulses !== 0 || div_pulses !== 2) begin
            failures++;
            $display("FAIL div_pulse: got mult=%0d div=%0d required 0 2", mult_pulses, div_pulses);
        end
    endtask

    task automatic test_exception();
        int cyc, w;
        bit ok;
        unit_lat = 2;
        send_req(1'b1, 32'd5, 32'd0, 5'd4, w, ok);
        wait_wb(20, cyc, ok);
        checks++;
        if (!ok || {mif.wb_rd, mif.wb_data, mif.wb_exception} !== {5'd30, 32'd5, 1'b1}) begin
            failures++;
            $display("FAIL div_zero: got rd=%0d data=%0d exc=%0d required 30 5 1", mif.wb_rd, mif.wb_data, mif.wb_exception);
        end
        @(posedge clock);
        #1;
        send_req(1'b0, 32'h4000_0000, 32'd4, 5'd6, w, ok);
        wait_wb(20, cyc, ok);
        checks++;
        if (!ok || {mif.wb_rd, mif.wb_data, mif.wb_exception} !== {5'd30, 32'd4, 1'b1}) begin
            failures++;
            $display("FAIL mult_ovf: got rd=%0d data=%0d exc=%0d required 30 4 1", mif.wb_rd, mif.wb_data, mif.wb_exception);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_backpressure();
        int cyc, w;
        bit ok;
        unit_lat     = 1;
        mif.wb_ready = 1'b0;
        send_req(1'b0, 32'd2, 32'd3, 5'd1, w, ok);
        wait_wb(20, cyc, ok);
        checks++;
        if (!ok) begin
            failures++;
            $display("FAIL bp_valid: wb_valid got 0 required 1");
        end
        for (int i = 0; i < 5; i++) begin
            if (i == 1) begin
                mif.req_valid    = 1'b1;
                mif.req_isDiv    = 1'b1;
                mif.req_operandA = 32'd99;
                mif.req_operandB = 32'd11;
                mif.req_rd       = 5'd17;
            end
            @(posedge clock);
            #1;
            mif.req_valid = 1'b0;
            checks++;
            if ({mif.wb_valid, mif.req_ready, mif.busy, mif.wb_rd, mif.wb_data, mif.wb_exception, mif.data_operandA}
                    !== {3'b101, 5'd1, 32'd6, 1'b0, 32'd2}) begin
                failures++;
                $display("FAIL bp_hold[%0d]: got valid=%0d ready=%0d busy=%0d rd=%0d data=%0d exc=%0d opA=%0d required 1 0 1 1 6 0 2",
                         i, mif.wb_valid, mif.req_ready, mif.busy, mif.wb_rd, mif.wb_data, mif.wb_exception, mif.data_operandA);
            end
        end
        mif.wb_ready = 1'b1;
        @(posedge clock);
        #1;
        checks++;
        if ({mif.wb_valid, mif.req_ready, mif.busy} !== 3'b010) begin
            failures++;
            $display("FAIL bp_release: got valid/ready/busy=%b required 010", {mif.wb_valid, mif.req_ready, mif.busy});
        end
        send_req(1'b0, 32'd9, 32'd9, 5'd2, w, ok);
        wait_wb(20, cyc, ok);
        checks++;
        if (!ok || w !== 0 || {mif.wb_rd, mif.wb_data, mif.wb_exception} !== {5'd2, 32'd81, 1'b0}) begin
            failures++;
            $display("FAIL bp_next: got waited=%0d rd=%0d data=%0d exc=%0d required 0 2 81 0",
                     w, mif.wb_rd, mif.wb_data, mif.wb_exception);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_timeout();
        int cyc, w;
        bit ok;
        unit_en = 1'b0;
        send_req(1'b0, 32'd1, 32'd1, 5'd5, w, ok);
        wait_wb(30, cyc, ok);
        checks++;
        if (!ok || cyc !== 9 || {mif.wb_rd, mif.wb_data, mif.wb_exception} !== {5'd30, 32'd4, 1'b1}) begin
            failures++;
            $display("FAIL timeout_mult: got edges=%0d rd=%0d data=%0d exc=%0d required 9 30 4 1",
                     cyc, mif.wb_rd, mif.wb_data, mif.wb_exception);
        end
        @(posedge clock);
        #1;
        send_req(1'b1, 32'd8, 32'd2, 5'd5, w, ok);
        wait_wb(30, cyc, ok);
        checks++;
        if (!ok || cyc !== 9 || {mif.wb_rd, mif.wb_data, mif.wb_exception} !== {5'd30, 32'd5, 1'b1}) begin
            failures++;
            $display("FAIL timeout_div: got edges=%0d rd=%0d data=%0d exc=%0d required 9 30 5 1",
                     cyc, mif.wb_rd, mif.wb_data, mif.wb_exception);
        end
        @(posedge clock);
        #1;
        unit_en = 1'b1;
    endtask

    task automatic test_reset_mid_wait();
        int cyc, w;
        bit ok;
        bit seen;
        unit_en  = 1'b0;
        unit_lat = 1;
        send_req(1'b1, 32'd50, 32'd5, 5'd8, w, ok);
        repeat (2) begin
            @(posedge clock);
            #1;
        end
        reset = 1'b1;
        #1;
        checks++;
        if ({mif.req_ready, mif.busy, mif.ctrl_MULT, mif.ctrl_DIV, mif.wb_valid, mif.data_operandA, mif.data_operandB}
                !== {5'b10000, 64'd0}) begin
            failures++;
            $display("FAIL rst_async: got ready=%0d busy=%0d mult=%0d div=%0d valid=%0d opA=%0d opB=%0d required 1 0 0 0 0 0 0",
                     mif.req_ready, mif.busy, mif.ctrl_MULT, mif.ctrl_DIV, mif.wb_valid, mif.data_operandA, mif.data_operandB);
        end
        @(posedge clock);
        #1 reset = 1'b0;
        late_rdy = 1'b1;
        late_res = 32'd123;
        @(posedge clock);
        #1 late_rdy = 1'b0;
        seen = mif.wb_valid;
        repeat (3) begin
            @(posedge clock);
            #1;
            seen = seen | mif.wb_valid;
        end
        checks++;
        if (seen !== 1'b0 || mif.req_ready !== 1'b1) begin
            failures++;
            $display("FAIL rst_late_rdy: got wb_valid seen=%0d ready=%0d required 0 1", seen, mif.req_ready);
        end
        unit_en = 1'b1;
        send_req(1'b0, 32'd3, 32'd5, 5'd7, w, ok);
        wait_wb(20, cyc, ok);
        checks++;
        if (!ok || {mif.wb_rd, mif.wb_data, mif.wb_exception} !== {5'd7, 32'd15, 1'b0}) begin
            failures++;
            $display("FAIL rst_recover: got rd=%0d data=%0d exc=%0d required 7 15 0", mif.wb_rd, mif.wb_data, mif.wb_exception);
        end
        @(posedge clock);
        #1;
    endtask

    task automatic test_back_to_back();
        int cyc, w;
        bit ok;
        unit_lat = 1;
        send_req(1'b0, 32'd7, 32'd3, 5'd11, w, ok);
        wait_wb(20, cyc, ok);
        checks++;
        if (!ok || {mif.wb_rd, mif.wb_data} !== {5'd11, 32'd21}) begin
            failures++;
            $display("FAIL b2b_first: got rd=%0d data=%0d required 11 21", mif.wb_rd, mif.wb_data);
        end
        // Request raised during the DONE handshake cycle must wait one edge
        send_req(1'b1, 32'd8, 32'd2, 5'd12, w, ok);
        checks++;
        if (!ok || w !== 1 || mif.data_operandA !== 32'd8) begin
            failures++;
            $display("FAIL b2b_accept: got waited=%0d opA=%0d required 1 8", w, mif.data_operandA);
        end
        wait_wb(20, cyc, ok);
        checks++;
        if (!ok || cyc !== 2 || {mif.wb_rd, mif.wb_data, mif.wb_exception} !== {5'd12, 32'd4, 1'b0}) begin
            failures++;
            $display("FAIL b2b_second: got edges=%0d rd=%0d data=%0d exc=%0d required 2 12 4 0",
                     cyc, mif.wb_rd, mif.wb_data, mif.wb_exception);
        end
        @(posedge clock);
        #1;
    endtask

    initial begin
        mif.req_valid    = 1'b0;
        mif.req_isDiv    = 1'b0;
        mif.req_operandA = '0;
        mif.req_operandB = '0;
        mif.req_rd       = '0;
        mif.wb_ready     = 1'b1;
        test_reset();
        test_mult();
        test_div();
        test_exception();
        test_backpressure();
        test_timeout();
        test_reset_mid_wait();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
